// File: rtl/ddr_serializer_pkg.sv
// Shared types and elaboration-time helpers for the DDR serializer.
package ddr_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int LANES_MIN = 1;
    localparam int LANES_MAX = 32;
    localparam int RATIO_MIN = 2;
    localparam int RATIO_MAX = 16;

    // Beat counter spans 0..ratio/2-1 but is never narrower than one bit.
    function automatic int beat_width(input int ratio);
        int w;
        w = $clog2(ratio / 2);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit params_ok(input int lanes, input int ratio);
        return (lanes >= LANES_MIN) && (lanes <= LANES_MAX) &&
               (ratio >= RATIO_MIN) && (ratio <= RATIO_MAX) &&
               (ratio % 2 == 0);
    endfunction

endpackage

// File: rtl/ddr_serializer_oddr.sv
// Generic DDR output cell: d2 drives the clk-high half, d1 the clk-low half of the cycle after sampling.
// No reset; the output follows whatever was registered on the last rising edge.
module ddr_serializer_oddr #(
    parameter TARGET = "RTL"
) (
    input  logic clk,
    input  logic d1,
    input  logic d2,
    output logic q
);

    logic d1_r;
    logic d2_r;

    always_ff @(posedge clk) begin
        d1_r <= d1;
        d2_r <= d2;
    end

    assign q = clk ? d2_r : d1_r;

endmodule

// File: rtl/ddr_serializer.sv
// Parallel-to-serial DDR output: RATIO bits per lane per word, 2 bits per lane per clk, first pair on q two cycles after transfer.
// s_ready only on IDLE or the last beat, so back-to-back words stream gap-free; a stalled word is held by the source.
module ddr_serializer
    import ddr_serializer_pkg::*;
#(
    parameter int   LANES     = 1,
    parameter int   RATIO     = 8,
    parameter bit   MSB_FIRST = 1'b0,
    parameter logic IDLE_VAL  = 1'b0,
    parameter       TARGET    = "RTL"
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*RATIO-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [LANES-1:0]       q,
    output logic                   busy,
    output logic                   underrun
);

    localparam int            BW   = beat_width(RATIO);
    localparam logic [BW-1:0] LAST = BW'(RATIO / 2 - 1);

    if (!params_ok(LANES, RATIO)) begin : g_bad_params
        $error("ddr_serializer: LANES must be 1..32 and RATIO even in 2..16");
    end

    state_t                 state, state_nxt;
    logic [BW-1:0]          beat, beat_nxt;
    logic [LANES*RATIO-1:0] shreg, shreg_nxt;
    logic [LANES*RATIO-1:0] load_word;
    logic [LANES*RATIO-1:0] shifted;
    logic [LANES-1:0]       d1;
    logic [LANES-1:0]       d2;
    logic                   xfer;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar b = 0; b < RATIO; b++) begin : g_bit
            assign load_word[l*RATIO+b] = MSB_FIRST ? s_data[l*RATIO+RATIO-1-b]
                                                    : s_data[l*RATIO+b];
        end

        // Consumed pair leaves the bottom; idle level refills from the top.
        if (RATIO == 2) begin : g_r2
            assign shifted[l*RATIO +: RATIO] = {RATIO{IDLE_VAL}};
        end else begin : g_rn
            assign shifted[l*RATIO +: RATIO] = {{2{IDLE_VAL}}, shreg[l*RATIO+2 +: RATIO-2]};
        end

        assign d2[l] = (state == SHIFT) ? shreg[l*RATIO]   : IDLE_VAL;
        assign d1[l] = (state == SHIFT) ? shreg[l*RATIO+1] : IDLE_VAL;

        ddr_serializer_oddr #(
            .TARGET (TARGET)
        ) u_oddr (
            .clk (clk),
            .d1  (d1[l]),
            .d2  (d2[l]),
            .q   (q[l])
        );
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        shreg_nxt = shreg;
        underrun  = 1'b0;
        s_ready   = !rst && ((state == IDLE) || (beat == LAST));
        xfer      = s_valid && s_ready;

        if (xfer) begin
            shreg_nxt = load_word;
            beat_nxt  = '0;
            state_nxt = SHIFT;
        end else if (state == SHIFT) begin
            shreg_nxt = shifted;
            if (beat == LAST) begin
                state_nxt = IDLE;
                beat_nxt  = '0;
                underrun  = !rst;
            end else begin
                beat_nxt = beat + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
            shreg <= {(LANES*RATIO){IDLE_VAL}};
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            shreg <= shreg_nxt;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_ddr_serializer.sv
// Directed bench for ddr_serializer: three configurations sharing one clock, per-cycle sample log checked afterwards.
module tb_ddr_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // A: 1 lane, RATIO 8, LSB first, idle 0
    logic       rst_a, a_valid, a_ready, a_busy, a_ur;
    logic [7:0] a_data;
    logic [0:0] a_q;
    // B: 2 lanes, RATIO 2, idle 1
    logic       rst_b, b_valid, b_ready, b_busy, b_ur;
    logic [3:0] b_data;
    logic [1:0] b_q;
    // C: 4 lanes, RATIO 4, MSB first, idle 0
    logic        rst_c, c_valid, c_ready, c_busy, c_ur;
    logic [15:0] c_data;
    logic [3:0]  c_q;

    ddr_serializer #(.LANES(1), .RATIO(8), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0), .TARGET("RTL")) u_a (
        .clk(clk), .rst(rst_a), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
        .q(a_q), .busy(a_busy), .underrun(a_ur));

    ddr_serializer #(.LANES(2), .RATIO(2), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1), .TARGET("RTL")) u_b (
        .clk(clk), .rst(rst_b), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
        .q(b_q), .busy(b_busy), .underrun(b_ur));

    ddr_serializer #(.LANES(4), .RATIO(4), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0), .TARGET("RTL")) u_c (
        .clk(clk), .rst(rst_c), .s_data(c_data), .s_valid(c_valid), .s_ready(c_ready),
        .q(c_q), .busy(c_busy), .underrun(c_ur));

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       rdy;
        logic       bsy;
        logic       ur;
    } smp_t;

    smp_t la [0:511];
    smp_t lb [0:511];
    smp_t lc [0:511];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Cycle k is the interval after rising edge k; sample mid-high and mid-low.
    always begin
        int k;
        @(posedge clk);
        cyc = cyc + 1;
        k = cyc;
        #2;
        if (k < 512) begin
            la[k].hi = {3'b0, a_q}; la[k].rdy = a_ready; la[k].bsy = a_busy; la[k].ur = a_ur;
            lb[k].hi = {2'b0, b_q}; lb[k].rdy = b_ready; lb[k].bsy = b_busy; lb[k].ur = b_ur;
            lc[k].hi = c_q;         lc[k].rdy = c_ready; lc[k].bsy = c_busy; lc[k].ur = c_ur;
        end
        #5;
        if (k < 512) begin
            la[k].lo = {3'b0, a_q};
            lb[k].lo = {2'b0, b_q};
            lc[k].lo = c_q;
        end
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // LSB-first bit stream of one 8-bit word on lane A starting at cycle 'start'.
    task automatic chk_a_word(input string tag, input int start, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            logic got;
            got = (i % 2 == 0) ? la[start + i/2].hi[0] : la[start + i/2].lo[0];
            expect_eq($sformatf("%s_bit%0d", tag, i), {31'b0, got}, {31'b0, w[i]});
        end
    endtask

    initial begin
        int c;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        a_data = '0; b_data = '0; c_data = '0;

        // Reset, then idle for 20 cycles
        tick(3);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick(20);
        expect_eq("rst_a_rdy", la[2].rdy, 0);
        expect_eq("rst_c_rdy", lc[2].rdy, 0);
        expect_eq("rst_a_busy", la[2].bsy, 0);
        expect_eq("rst_a_ur", la[2].ur, 0);
        expect_eq("rst_a_q", {la[2].hi, la[2].lo}, 8'h00);
        expect_eq("rst_b_q", {lb[2].hi, lb[2].lo}, 8'h33);
        for (int k = 4; k < 23; k++) begin
            expect_eq($sformatf("idle_b_q_c%0d", k), {lb[k].hi, lb[k].lo}, 8'h33);
        end
        expect_eq("idle_b_rdy", lb[22].rdy, 1);
        expect_eq("idle_b_busy", lb[22].bsy, 0);

        // Single word 0xA5
        c = cyc;
        a_data = 8'hA5; a_valid = 1'b1;
        tick(1);
        a_valid = 1'b0;
        tick(8);
        chk_a_word("single_a5", c + 2, 8'hA5);
        expect_eq("single_busy0", la[c+1].bsy, 1);
        expect_eq("single_rdy_beat0", la[c+1].rdy, 0);
        expect_eq("single_rdy_beat3", la[c+4].rdy, 1);
        expect_eq("single_ur_beat2", la[c+3].ur, 0);
        expect_eq("single_ur_beat3", la[c+4].ur, 1);
        expect_eq("single_ur_after", la[c+5].ur, 0);
        expect_eq("single_busy_after", la[c+5].bsy, 0);
        expect_eq("single_idle_q", {la[c+6].hi, la[c+6].lo}, 8'h00);

        // Back-to-back 0xFF then 0x00, valid held
        c = cyc;
        a_data = 8'hFF; a_valid = 1'b1;
        tick(1);
        a_data = 8'h00;
        tick(4);
        a_valid = 1'b0;
        tick(6);
        chk_a_word("b2b_ff", c + 2, 8'hFF);
        chk_a_word("b2b_00", c + 6, 8'h00);
        expect_eq("b2b_rdy_beat3", la[c+4].rdy, 1);
        expect_eq("b2b_no_ur", la[c+4].ur, 0);
        for (int k = 1; k <= 8; k++) begin
            expect_eq($sformatf("b2b_busy_c%0d", k), la[c+k].bsy, 1);
        end
        expect_eq("b2b_ur_end", la[c+8].ur, 1);

        // Backpressure: 0x3C presented while 0xA5 shifts
        c = cyc;
        a_data = 8'hA5; a_valid = 1'b1;
        tick(1);
        a_data = 8'h3C;
        tick(4);
        a_valid = 1'b0;
        tick(6);
        expect_eq("bp_rdy_held", la[c+2].rdy, 0);
        expect_eq("bp_rdy_last", la[c+4].rdy, 1);
        expect_eq("bp_no_ur", la[c+4].ur, 0);
        chk_a_word("bp_a5", c + 2, 8'hA5);
        chk_a_word("bp_3c", c + 6, 8'h3C);
        expect_eq("bp_ur_end", la[c+8].ur, 1);

        // Reset at beat 1 of 0xA5, then 0x0F
        c = cyc;
        a_data = 8'hA5; a_valid = 1'b1;
        tick(1);
        a_valid = 1'b0;
        tick(1);
        rst_a = 1'b1;
        tick(2);
        rst_a = 1'b0;
        a_data = 8'h0F; a_valid = 1'b1;
        tick(1);
        a_valid = 1'b0;
        tick(6);
        expect_eq("rmid_rdy_in_rst", la[c+2].rdy, 0);
        expect_eq("rmid_busy", la[c+3].bsy, 0);
        expect_eq("rmid_q_idle", {la[c+4].hi, la[c+4].lo}, 8'h00);
        for (int k = 2; k <= 5; k++) begin
            expect_eq($sformatf("rmid_no_ur_c%0d", k), la[c+k].ur, 0);
        end
        expect_eq("rmid_rdy_out", la[c+4].rdy, 1);
        chk_a_word("rmid_0f", c + 6, 8'h0F);
        expect_eq("rmid_ur_end", la[c+8].ur, 1);

        // 4 lanes, RATIO 4, MSB first, 16'h1248
        c = cyc;
        c_data = 16'h1248; c_valid = 1'b1;
        tick(1);
        c_valid = 1'b0;
        tick(5);
        expect_eq("lanes_hi0", lc[c+2].hi, 4'h1);
        expect_eq("lanes_lo0", lc[c+2].lo, 4'h2);
        expect_eq("lanes_hi1", lc[c+3].hi, 4'h4);
        expect_eq("lanes_lo1", lc[c+3].lo, 4'h8);
        expect_eq("lanes_idle", {lc[c+4].hi, lc[c+4].lo}, 8'h00);
        expect_eq("lanes_ur_beat0", lc[c+1].ur, 0);
        expect_eq("lanes_ur_last", lc[c+2].ur, 1);
        expect_eq("lanes_rdy_last", lc[c+2].rdy, 1);

        // 2 lanes, RATIO 2, idle 1: single-beat word
        c = cyc;
        b_data = 4'b0110; b_valid = 1'b1;
        tick(1);
        b_valid = 1'b0;
        tick(4);
        expect_eq("r2_rdy_beat0", lb[c+1].rdy, 1);
        expect_eq("r2_ur_beat0", lb[c+1].ur, 1);
        expect_eq("r2_hi", lb[c+2].hi, 4'h2);
        expect_eq("r2_lo", lb[c+2].lo, 4'h1);
        expect_eq("r2_idle", {lb[c+3].hi, lb[c+3].lo}, 8'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ddr_serializer.md
Name: ddr_serializer

Overview:
- Parametrised parallel-to-serial DDR output block: accepts words of RATIO bits per lane and emits 2 bits per lane per clk through one oddr per lane.
- Generalises the single-bit oddr in four ways: lane count, serialization ratio, valid/ready streaming, and defined idle/underrun behaviour.
- Sits between a fabric-side word stream (e.g. a source-synchronous TX path) and the output pins.

Parameters:
- LANES, 1, number of independent output lanes (1..32).
- RATIO, 8, bits per lane per word; must be even, 2..16. Elaboration error otherwise.
- MSB_FIRST, 0, 0 = bit 0 of each lane slice goes out first; 1 = bit RATIO-1 goes out first.
- IDLE_VAL, 1'b0, level driven on every lane when no word is being shifted.
- TARGET, "RTL", passed unchanged to each oddr instance.

Ports:
- clk  in  1  single clock for the whole block; also the DDR output clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  LANES*RATIO  word; lane n occupies bits [n*RATIO +: RATIO].
- s_valid  in  1  word valid.
- s_ready  out  1  block can accept a word this cycle.
- q  out  LANES  serial DDR outputs, one per lane.
- busy  out  1  a word is currently being shifted.
- underrun  out  1  one-cycle pulse when a word finishes and no next word follows.

Behaviour:
- States: IDLE, SHIFT. Beat counter spans 0..RATIO/2-1; its width is max(1, clog2(RATIO/2)).
- Handshake: a word transfers in any cycle where s_valid && s_ready.
- s_ready = (state==IDLE) || (beat==RATIO/2-1). This allows back-to-back words with no gap. s_ready is low while rst is high.
- The source must hold s_data stable while s_valid=1 and s_ready=0.
- On transfer:
  - load the shift register (reordered if MSB_FIRST);
  - set beat=0;
  - set state=SHIFT.
- In SHIFT, each cycle presents one bit pair per lane to its oddr, then advances beat and shifts by 2.
- When beat==RATIO/2-1:
  - if a transfer occurs, reload and stay in SHIFT;
  - else go to IDLE and pulse underrun for that cycle.
- Pair mapping: the first-in-time bit goes to oddr d2 and the second to oddr d1. The first bit therefore occupies the clk-high half and the second the clk-low half of the cycle after sampling.
- In IDLE, d1 = d2 = IDLE_VAL on all lanes.
- Latency: for a transfer in cycle c, the first bit pair appears on q during cycle c+2. A word occupies RATIO/2 consecutive cycles on q.
- busy = (state==SHIFT), registered.
- Reset values: state=IDLE, beat=0, shift register=all IDLE_VAL, s_ready=0 during rst, busy=0, underrun=0.
- q reaches IDLE_VAL no later than 2 cycles after rst is sampled high (the generic oddr has no reset, so the flush goes through its register).
- Reset mid-word: the remaining bits are discarded. The next word starts cleanly after rst deasserts, with s_ready=1 in the first cycle out of reset.
- underrun is not asserted on reset or on leaving IDLE.

Decomposition:
- Package ddr_serializer_pkg:
  - state enum (IDLE, SHIFT);
  - beat-width function;
  - RATIO/LANES legality-check constants.
- One natural sub-module: the existing oddr, instantiated per lane in a generate loop with TARGET passed through.
- Shift/beat/handshake logic stays in ddr_serializer.

Test Plan:
- LANES=1, RATIO=8, one word 0xA5 at cycle c:
  - q half-cycle sequence from c+2 is 1,0,1,0,0,1,0,1 over 4 cycles;
  - then IDLE_VAL;
  - underrun pulses at beat 3.
- Back-to-back words 0xFF then 0x00 with s_valid held:
  - s_ready is high on beat 3 of the first word;
  - 8 ones are followed immediately by 8 zeros, no idle gap;
  - no underrun between the words.
- Backpressure: present 0x3C while a word is shifting with s_ready=0:
  - the word is held, not lost;
  - it transfers on the last beat;
  - its bits follow contiguously.
- Reset asserted at beat 1 of word 0xA5:
  - q is IDLE_VAL within 2 cycles;
  - busy=0, no underrun;
  - the next word 0x0F after reset serializes correctly.
- LANES=4, RATIO=4, MSB_FIRST=1, s_data=16'h1248:
  - each lane emits its own nibble MSB-first;
  - lanes stay cycle-aligned with no crosstalk.
- IDLE_VAL=1, no stimulus for 20 cycles: q stays 1 on all lanes, s_ready=1, busy=0.
